// File: rtl/mole_controller_if.sv
// Signal bundle between the mole round sequencer and the game top level:
// tick/start/button inputs in, LED bank, counters and status flags out.
interface mole_controller_if #(
    parameter int unsigned MOLE_W  = 3,
    parameter int unsigned SCORE_W = 8,
    parameter int unsigned MISS_W  = 4
);
    localparam int unsigned NUM_MOLES = 1 << MOLE_W;

    logic                 tick;
    logic                 start;
    logic [NUM_MOLES-1:0] buttons;
    logic [NUM_MOLES-1:0] mole_leds;
    logic [SCORE_W-1:0]   score;
    logic [MISS_W-1:0]    misses;
    logic                 hit_pulse;
    logic                 game_over;

    modport master (
        output tick, start, buttons,
        input  mole_leds, score, misses, hit_pulse, game_over
    );

    modport slave (
        input  tick, start, buttons,
        output mole_leds, score, misses, hit_pulse, game_over
    );
endinterface

// File: rtl/mole_controller.sv
// Whack-a-mole round sequencer: lights one pseudo-random mole per round on the
// difficulty tick, scores hits, counts misses and flags game over.
module mole_controller #(
    parameter int unsigned MOLE_W     = 3,
    parameter int unsigned UP_TICKS   = 4,
    parameter int unsigned GAP_TICKS  = 1,
    parameter int unsigned MAX_MISSES = 5,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned MISS_W     = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              clkglobal,
    input  logic              resetglobal,
    mole_controller_if.slave  bus
);
    localparam int unsigned NUM_MOLES = 1 << MOLE_W;
    localparam int unsigned UP_W      = (UP_TICKS > 1) ? $clog2(UP_TICKS) : 1;
    localparam int unsigned GAP_W     = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        UP    = 3'd2,
        GAP   = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 tick_q, start_q;
    logic [NUM_MOLES-1:0] btn_q;
    logic                 tick_p, start_p;
    logic [NUM_MOLES-1:0] btn_p;
    logic [15:0]          lfsr_q;
    logic                 lfsr_fb;
    logic [MOLE_W-1:0]    idx_q, idx_d;
    logic [UP_W-1:0]      up_cnt_q, up_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [NUM_MOLES-1:0] leds_q, leds_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [MISS_W-1:0]    misses_q, misses_d;
    logic                 hit_q, hit_d;
    logic                 over_q, over_d;

    logic [MOLE_W-1:0]    spawn_idx;
    logic [NUM_MOLES-1:0] lit_mask;
    logic                 lit_press;
    logic                 wrong_press;
    logic [SCORE_W-1:0]   score_inc;
    logic [MISS_W-1:0]    misses_inc;

    // Fibonacci LFSR, taps 16,14,13,11
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // State register plus edge detectors, LFSR and registered outputs
    always_ff @(posedge clkglobal) begin
        if (!resetglobal) begin
            state_q   <= IDLE;
            tick_q    <= 1'b0;
            start_q   <= 1'b0;
            btn_q     <= '0;
            tick_p    <= 1'b0;
            start_p   <= 1'b0;
            btn_p     <= '0;
            lfsr_q    <= LFSR_SEED;
            idx_q     <= '0;
            up_cnt_q  <= '0;
            gap_cnt_q <= '0;
            leds_q    <= '0;
            score_q   <= '0;
            misses_q  <= '0;
            hit_q     <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= bus.tick;
            start_q   <= bus.start;
            btn_q     <= bus.buttons;
            tick_p    <= bus.tick & ~tick_q;
            start_p   <= bus.start & ~start_q;
            btn_p     <= bus.buttons & ~btn_q;
            lfsr_q    <= {lfsr_q[14:0], lfsr_fb};
            idx_q     <= idx_d;
            up_cnt_q  <= up_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            leds_q    <= leds_d;
            score_q   <= score_d;
            misses_q  <= misses_d;
            hit_q     <= hit_d;
            over_q    <= over_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        up_cnt_d  = up_cnt_q;
        gap_cnt_d = gap_cnt_q;
        leds_d    = leds_q;
        score_d   = score_q;
        misses_d  = misses_q;
        hit_d     = 1'b0;

        // Never light the same mole twice in a row
        spawn_idx = lfsr_q[MOLE_W-1:0];
        if (spawn_idx == idx_q)
            spawn_idx = spawn_idx + MOLE_W'(1);

        lit_mask    = NUM_MOLES'(1) << idx_q;
        lit_press   = btn_p[idx_q];
        wrong_press = |(btn_p & ~lit_mask);
        score_inc   = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
        misses_inc  = (misses_q == '1) ? misses_q : misses_q + MISS_W'(1);

        case (state_q)
            IDLE: begin
                leds_d = '0;
            end
            SPAWN: begin
                leds_d   = NUM_MOLES'(1) << spawn_idx;
                idx_d    = spawn_idx;
                up_cnt_d = '0;
                state_d  = UP;
            end
            UP: begin
                // Hit beats expiry beats wrong press; a non-expiring tick still
                // lets a wrong press count
                if (lit_press) begin
                    score_d   = score_inc;
                    hit_d     = 1'b1;
                    leds_d    = '0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else if (tick_p && (up_cnt_q == UP_W'(UP_TICKS - 1))) begin
                    misses_d  = misses_inc;
                    leds_d    = '0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else begin
                    if (tick_p)
                        up_cnt_d = up_cnt_q + UP_W'(1);
                    if (wrong_press)
                        misses_d = misses_inc;
                end
            end
            GAP: begin
                leds_d = '0;
                if (misses_q >= MISS_W'(MAX_MISSES)) begin
                    state_d = OVER;
                end else if (tick_p) begin
                    if (gap_cnt_q == GAP_W'(GAP_TICKS - 1))
                        state_d = SPAWN;
                    else
                        gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            OVER: begin
                leds_d = '0;
            end
            default: begin
                leds_d  = '0;
                state_d = IDLE;
            end
        endcase

        // Start edge (re)starts a game from any state except the one-cycle spawn
        if (start_p && (state_q != SPAWN)) begin
            score_d  = '0;
            misses_d = '0;
            leds_d   = '0;
            hit_d    = 1'b0;
            state_d  = SPAWN;
        end

        over_d = (state_d == OVER);
    end

    assign bus.mole_leds = leds_q;
    assign bus.score     = score_q;
    assign bus.misses    = misses_q;
    assign bus.hit_pulse = hit_q;
    assign bus.game_over = over_q;
endmodule

// File: tb/tb_mole_controller.sv
// Self-checking bench for mole_controller: directed scenarios plus a randomized
// game checked against a saturating score/miss model.
module tb_mole_controller;
    localparam int unsigned MOLE_W     = 3;
    localparam int unsigned NUM_MOLES  = 1 << MOLE_W;
    localparam int unsigned UP_TICKS   = 4;
    localparam int unsigned GAP_TICKS  = 1;
    localparam int unsigned MAX_MISSES = 5;
    localparam int unsigned SCORE_W    = 2;
    localparam int unsigned MISS_W     = 4;
    localparam int          SCORE_MAX  = (1 << SCORE_W) - 1;
    localparam int          MISS_MAX   = (1 << MISS_W) - 1;

    logic clkglobal = 1'b0;
    logic resetglobal;
    always #5 clkglobal = ~clkglobal;

    mole_controller_if #(.MOLE_W(MOLE_W), .SCORE_W(SCORE_W), .MISS_W(MISS_W)) bus ();

    mole_controller #(
        .MOLE_W(MOLE_W), .UP_TICKS(UP_TICKS), .GAP_TICKS(GAP_TICKS),
        .MAX_MISSES(MAX_MISSES), .SCORE_W(SCORE_W), .MISS_W(MISS_W),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clkglobal(clkglobal),
        .resetglobal(resetglobal),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int m_score  = 0;
    int m_misses = 0;
    int prev_idx = -1;
    int cur_idx  = -1;

    task automatic cyc(input int n);
        repeat (n) @(negedge clkglobal);
    endtask

    task automatic do_tick();
        bus.tick = 1'b1; cyc(2);
        bus.tick = 1'b0; cyc(2);
    endtask

    task automatic expire_mole();
        repeat (UP_TICKS) do_tick();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1; cyc(1);
        bus.start = 1'b0;
    endtask

    // Press a button set, release, and count hit_pulse cycles seen meanwhile
    task automatic press(input logic [NUM_MOLES-1:0] mask, output int pulses);
        pulses = 0;
        bus.buttons = mask;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            if (bus.hit_pulse === 1'b1) pulses++;
            if (i == 1) bus.buttons = '0;
        end
    endtask

    // Wait up to budget cycles for a lit LED; idx = -1 on timeout or non-one-hot
    task automatic wait_lit(input int budget, output int idx);
        idx = -1;
        for (int k = 0; k <= budget; k++) begin
            if (bus.mole_leds !== '0) begin
                if ($onehot(bus.mole_leds))
                    for (int b = 0; b < NUM_MOLES; b++)
                        if (bus.mole_leds[b] === 1'b1) idx = b;
                break;
            end
            if (k < budget) cyc(1);
        end
    endtask

    function automatic int sat_inc(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    function automatic int other_idx(input int k);
        return (k + int'($urandom_range(1, NUM_MOLES - 1))) % NUM_MOLES;
    endfunction

    task automatic test_reset();
        resetglobal = 1'b0;
        bus.tick = 1'b0; bus.start = 1'b0; bus.buttons = '0;
        cyc(3);
        checks++;
        if ({bus.mole_leds, bus.score, bus.misses, bus.hit_pulse, bus.game_over} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: leds=%b score=%0d misses=%0d hit=%b over=%b, expected all 0",
                     bus.mole_leds, bus.score, bus.misses, bus.hit_pulse, bus.game_over);
        end
        resetglobal = 1'b1;
        do_tick();
        checks++;
        if (bus.mole_leds !== '0 || bus.game_over !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: leds=%b over=%b, expected 0 without start", bus.mole_leds, bus.game_over);
        end
        m_score = 0; m_misses = 0; prev_idx = -1;
    endtask

    task automatic test_start();
        pulse_start();
        wait_lit(2, cur_idx);
        checks++;
        if (cur_idx < 0) begin
            failures++;
            $display("FAIL start_spawn: leds=%b, expected one LED lit within 3 clocks", bus.mole_leds);
        end
        prev_idx = cur_idx;
    endtask

    task automatic test_hit();
        int pulses;
        press(NUM_MOLES'(1) << cur_idx, pulses);
        m_score = sat_inc(m_score, SCORE_MAX);
        checks++;
        if (bus.score !== SCORE_W'(m_score) || pulses != 1 || bus.mole_leds !== '0 || bus.misses !== '0) begin
            failures++;
            $display("FAIL hit: score=%0d pulses=%0d leds=%b misses=%0d, expected score=%0d pulses=1 leds=0 misses=0",
                     bus.score, pulses, bus.mole_leds, bus.misses, m_score);
        end
        do_tick();
        wait_lit(4, cur_idx);
        checks++;
        if (cur_idx < 0 || cur_idx == prev_idx) begin
            failures++;
            $display("FAIL hit_respawn: idx=%0d leds=%b, expected one-hot and != %0d", cur_idx, bus.mole_leds, prev_idx);
        end
        prev_idx = cur_idx;
    endtask

    task automatic test_expire();
        repeat (UP_TICKS - 1) do_tick();
        checks++;
        if (bus.mole_leds !== NUM_MOLES'(1) << cur_idx || bus.misses !== MISS_W'(m_misses)) begin
            failures++;
            $display("FAIL expire_early: leds=%b misses=%0d, expected mole %0d still lit, misses=%0d",
                     bus.mole_leds, bus.misses, cur_idx, m_misses);
        end
        do_tick();
        m_misses = sat_inc(m_misses, MISS_MAX);
        checks++;
        if (bus.misses !== MISS_W'(m_misses) || bus.mole_leds !== '0) begin
            failures++;
            $display("FAIL expire: misses=%0d leds=%b, expected misses=%0d leds=0", bus.misses, bus.mole_leds, m_misses);
        end
        do_tick();
        wait_lit(4, cur_idx);
        checks++;
        if (cur_idx < 0 || cur_idx == prev_idx) begin
            failures++;
            $display("FAIL expire_respawn: idx=%0d, expected one-hot and != %0d", cur_idx, prev_idx);
        end
        prev_idx = cur_idx;
    endtask

    task automatic test_hit_and_wrong();
        int pulses;
        press((NUM_MOLES'(1) << cur_idx) | (NUM_MOLES'(1) << other_idx(cur_idx)), pulses);
        m_score = sat_inc(m_score, SCORE_MAX);
        checks++;
        if (bus.score !== SCORE_W'(m_score) || bus.misses !== MISS_W'(m_misses) || pulses != 1) begin
            failures++;
            $display("FAIL hit_and_wrong: score=%0d misses=%0d pulses=%0d, expected %0d %0d 1",
                     bus.score, bus.misses, pulses, m_score, m_misses);
        end
        do_tick();
        wait_lit(4, cur_idx);
        checks++;
        if (cur_idx < 0 || cur_idx == prev_idx) begin
            failures++;
            $display("FAIL hw_respawn: idx=%0d, expected one-hot and != %0d", cur_idx, prev_idx);
        end
        prev_idx = cur_idx;
    endtask

    // A long high or low level on tick is a single pulse at most
    task automatic test_tick_level();
        bus.tick = 1'b1; cyc(20);
        bus.tick = 1'b0; cyc(20);
        repeat (UP_TICKS - 2) do_tick();
        checks++;
        if (bus.mole_leds !== NUM_MOLES'(1) << cur_idx || bus.misses !== MISS_W'(m_misses)) begin
            failures++;
            $display("FAIL tick_level: leds=%b misses=%0d, expected mole %0d lit, misses=%0d",
                     bus.mole_leds, bus.misses, cur_idx, m_misses);
        end
        do_tick();
        m_misses = sat_inc(m_misses, MISS_MAX);
        checks++;
        if (bus.misses !== MISS_W'(m_misses) || bus.mole_leds !== '0) begin
            failures++;
            $display("FAIL tick_level_expire: misses=%0d leds=%b, expected %0d and 0", bus.misses, bus.mole_leds, m_misses);
        end
        do_tick();
        wait_lit(4, cur_idx);
        prev_idx = cur_idx;
    endtask

    task automatic test_score_saturate();
        int pulses;
        for (int i = 0; i < 3; i++) begin
            press(NUM_MOLES'(1) << cur_idx, pulses);
            m_score = sat_inc(m_score, SCORE_MAX);
            checks++;
            if (bus.score !== SCORE_W'(m_score) || pulses != 1) begin
                failures++;
                $display("FAIL score_sat: score=%0d pulses=%0d, expected score=%0d pulses=1", bus.score, pulses, m_score);
            end
            do_tick();
            wait_lit(4, cur_idx);
            checks++;
            if (cur_idx < 0 || cur_idx == prev_idx) begin
                failures++;
                $display("FAIL sat_respawn: idx=%0d, expected one-hot and != %0d", cur_idx, prev_idx);
            end
            prev_idx = cur_idx;
        end
    endtask

    task automatic test_restart();
        pulse_start(); cyc(1);
        m_score = 0; m_misses = 0;
        checks++;
        if (bus.score !== '0 || bus.misses !== '0 || bus.mole_leds !== '0) begin
            failures++;
            $display("FAIL restart: score=%0d misses=%0d leds=%b, expected all 0", bus.score, bus.misses, bus.mole_leds);
        end
        wait_lit(2, cur_idx);
        checks++;
        if (cur_idx < 0 || cur_idx == prev_idx) begin
            failures++;
            $display("FAIL restart_spawn: idx=%0d, expected one-hot and != %0d", cur_idx, prev_idx);
        end
        prev_idx = cur_idx;
    endtask

    task automatic test_game_over();
        for (int i = 0; i < MAX_MISSES; i++) begin
            expire_mole();
            m_misses = sat_inc(m_misses, MISS_MAX);
            checks++;
            if (bus.misses !== MISS_W'(m_misses) || bus.game_over !== (m_misses >= MAX_MISSES) || bus.mole_leds !== '0) begin
                failures++;
                $display("FAIL game_over_%0d: misses=%0d over=%b leds=%b, expected misses=%0d over=%0d leds=0",
                         i, bus.misses, bus.game_over, bus.mole_leds, m_misses, m_misses >= MAX_MISSES);
            end
            if (m_misses < MAX_MISSES) begin
                do_tick();
                wait_lit(4, cur_idx);
                prev_idx = cur_idx;
            end
        end
        do_tick();
        checks++;
        if (bus.mole_leds !== '0 || bus.game_over !== 1'b1) begin
            failures++;
            $display("FAIL over_hold: leds=%b over=%b, expected leds=0 over=1", bus.mole_leds, bus.game_over);
        end
        pulse_start(); cyc(1);
        m_score = 0; m_misses = 0;
        checks++;
        if (bus.score !== '0 || bus.misses !== '0 || bus.game_over !== 1'b0) begin
            failures++;
            $display("FAIL over_restart: score=%0d misses=%0d over=%b, expected 0 0 0", bus.score, bus.misses, bus.game_over);
        end
        wait_lit(2, cur_idx);
        prev_idx = cur_idx;
    endtask

    task automatic test_random_game(input int rounds);
        int act, pulses;
        logic [NUM_MOLES-1:0] lit, mask;
        for (int r = 0; r < rounds; r++) begin
            lit = NUM_MOLES'(1) << cur_idx;
            act = int'($urandom_range(0, 7));
            if (act == 7) begin
                pulse_start(); cyc(1);
                m_score = 0; m_misses = 0;
                checks++;
                if (bus.score !== '0 || bus.misses !== '0) begin
                    failures++;
                    $display("FAIL rnd_restart: score=%0d misses=%0d, expected 0 0", bus.score, bus.misses);
                end
                wait_lit(2, cur_idx);
            end else begin
                if (act <= 2) begin
                    mask = lit;
                    if ($urandom_range(0, 1) == 1) mask = mask | (NUM_MOLES'(1) << other_idx(cur_idx));
                    press(mask, pulses);
                    m_score = sat_inc(m_score, SCORE_MAX);
                    checks++;
                    if (pulses != 1 || bus.mole_leds !== '0) begin
                        failures++;
                        $display("FAIL rnd_hit: pulses=%0d leds=%b, expected 1 and 0", pulses, bus.mole_leds);
                    end
                end else begin
                    if (act <= 4) begin
                        press(NUM_MOLES'(1) << other_idx(cur_idx), pulses);
                        m_misses = sat_inc(m_misses, MISS_MAX);
                        checks++;
                        if (bus.misses !== MISS_W'(m_misses) || bus.mole_leds !== lit || pulses != 0) begin
                            failures++;
                            $display("FAIL rnd_wrong: misses=%0d leds=%b pulses=%0d, expected %0d %b 0",
                                     bus.misses, bus.mole_leds, pulses, m_misses, lit);
                        end
                    end
                    expire_mole();
                    m_misses = sat_inc(m_misses, MISS_MAX);
                end
                checks++;
                if (bus.score !== SCORE_W'(m_score) || bus.misses !== MISS_W'(m_misses) ||
                    bus.game_over !== (m_misses >= MAX_MISSES)) begin
                    failures++;
                    $display("FAIL rnd_counts: score=%0d misses=%0d over=%b, expected %0d %0d %0d",
                             bus.score, bus.misses, bus.game_over, m_score, m_misses, m_misses >= MAX_MISSES);
                end
                if (m_misses >= MAX_MISSES) begin
                    pulse_start(); cyc(1);
                    m_score = 0; m_misses = 0;
                    wait_lit(2, cur_idx);
                end else begin
                    do_tick();
                    wait_lit(4, cur_idx);
                end
            end
            checks++;
            if (cur_idx < 0 || cur_idx == prev_idx) begin
                failures++;
                $display("FAIL rnd_spawn: idx=%0d leds=%b, expected one-hot and != %0d", cur_idx, bus.mole_leds, prev_idx);
            end
            prev_idx = cur_idx;
            if (cur_idx < 0) return;
        end
    endtask

    task automatic test_miss_saturate();
        int pulses;
        for (int i = 0; i < MISS_MAX + 2; i++) begin
            press(NUM_MOLES'(1) << other_idx(cur_idx), pulses);
            m_misses = sat_inc(m_misses, MISS_MAX);
        end
        checks++;
        if (bus.misses !== MISS_W'(m_misses) || bus.mole_leds !== NUM_MOLES'(1) << cur_idx) begin
            failures++;
            $display("FAIL miss_sat: misses=%0d leds=%b, expected %0d with mole %0d lit",
                     bus.misses, bus.mole_leds, m_misses, cur_idx);
        end
        expire_mole();
        m_misses = sat_inc(m_misses, MISS_MAX);
        checks++;
        if (bus.misses !== MISS_W'(m_misses) || bus.game_over !== 1'b1) begin
            failures++;
            $display("FAIL miss_sat_over: misses=%0d over=%b, expected %0d and 1", bus.misses, bus.game_over, m_misses);
        end
        pulse_start(); cyc(1);
        m_score = 0; m_misses = 0;
        wait_lit(2, cur_idx);
        prev_idx = cur_idx;
    endtask

    task automatic test_reset_mid_up();
        int pulses;
        press(NUM_MOLES'(1) << cur_idx, pulses);
        do_tick();
        wait_lit(4, cur_idx);
        resetglobal = 1'b0; cyc(1);
        checks++;
        if ({bus.mole_leds, bus.score, bus.misses, bus.hit_pulse, bus.game_over} !== '0) begin
            failures++;
            $display("FAIL reset_mid_up: leds=%b score=%0d misses=%0d hit=%b over=%b, expected all 0",
                     bus.mole_leds, bus.score, bus.misses, bus.hit_pulse, bus.game_over);
        end
        resetglobal = 1'b1;
        do_tick(); do_tick();
        checks++;
        if (bus.mole_leds !== '0 || bus.score !== '0) begin
            failures++;
            $display("FAIL reset_mid_idle: leds=%b score=%0d, expected idle with 0", bus.mole_leds, bus.score);
        end
        prev_idx = -1;
        test_start();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start();
        test_hit();
        test_expire();
        test_hit_and_wrong();
        test_tick_level();
        test_score_saturate();
        test_restart();
        test_game_over();
        test_random_game(40);
        test_miss_saturate();
        test_reset_mid_up();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
